i2s_wb_slave: RTL and testbench

I2S_WB_SLAVE -- requirements
Module: i2s_wb_slave

---
 rtl/i2s_wb_slave.sv | 220 ++++++++++++++++++++++
 tb/tb_i2s_wb_slave.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_wb_slave.sv
// Wishbone classic slave that moves audio samples between a bus master and
// I2S transmit/receive cores. It holds the control, status and data registers
// and one TX FIFO and one RX FIFO.
//
// Bus handshake FSM
//   state   | meaning
//   ST_IDLE | waiting for cyc & stb, ack low
//   ST_ACK  | ack high for one cycle; the register write or FIFO pop happens here
module i2s_wb_slave #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic        wb_sel_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [2:0]  wb_cti_i,
   input  logic [1:0]  wb_bte_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic [31:0] tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   input  logic [31:0] rx_data_i,
   input  logic        rx_valid_i,
   output logic        irq_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_TXDATA = 2'd2;
   localparam logic [1:0] REG_RXDATA = 2'd3;

   typedef enum logic {ST_IDLE, ST_ACK} ack_state_t;

   ack_state_t state, state_nxt;

   logic        tx_en, rx_en, irq_txe_en, irq_rxne_en;
   logic        rx_overrun, tx_overflow;

   logic [31:0]   tx_mem [FIFO_DEPTH];
   logic [AW-1:0] tx_wptr, tx_rptr;
   logic [CW-1:0] tx_count;
   logic          tx_full, tx_empty;

   logic [31:0]   rx_mem [FIFO_DEPTH];
   logic [AW-1:0] rx_wptr, rx_rptr;
   logic [CW-1:0] rx_count;
   logic          rx_full, rx_empty;

   logic        access, mapped, wr, rd;
   logic [1:0]  reg_sel;
   logic        wr_ctrl, wr_status, fifo_clr;
   logic        tx_push, tx_push_ok, tx_pop;
   logic        rx_push, rx_push_ok, rx_pop;
   logic [4:0]  tx_count5, rx_count5;
   logic [31:0] status_word;
   logic [31:0] rd_data;

   // Burst hints and byte-lane address bits carry no meaning for this slave.
   logic unused_bits;
   assign unused_bits = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

   // Handshake state register; reset abandons any access in flight.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) state <= ST_IDLE;
      else           state <= state_nxt;
   end

   // Ack the cycle after a strobe is seen, then drop for one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (wb_cyc_i && wb_stb_i) state_nxt = ST_ACK;
         ST_ACK:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign wb_ack_o = (state == ST_ACK);

   // Decode; every side effect is taken on the ack cycle only.
   assign access    = wb_ack_o & wb_cyc_i & wb_stb_i;
   assign mapped    = (wb_adr_i[31:4] == 28'd0);
   assign reg_sel   = wb_adr_i[3:2];
   assign wr        = access & wb_we_i & wb_sel_i & mapped;
   assign rd        = access & ~wb_we_i & mapped;
   assign wr_ctrl   = wr & (reg_sel == REG_CTRL);
   assign wr_status = wr & (reg_sel == REG_STATUS);
   assign fifo_clr  = wr_ctrl & wb_dat_i[4];

   assign tx_full    = (tx_count == DEPTH_C);
   assign tx_empty   = (tx_count == '0);
   assign tx_valid_o = tx_en & ~tx_empty;
   assign tx_data_o  = tx_mem[tx_rptr];
   assign tx_pop     = tx_valid_o & tx_ready_i;
   assign tx_push    = wr & (reg_sel == REG_TXDATA);
   assign tx_push_ok = tx_push & (~tx_full | tx_pop);

   assign rx_full    = (rx_count == DEPTH_C);
   assign rx_empty   = (rx_count == '0);
   assign rx_pop     = rd & (reg_sel == REG_RXDATA) & ~rx_empty;
   assign rx_push    = rx_valid_i & rx_en;
   assign rx_push_ok = rx_push & (~rx_full | rx_pop);

   // Control bits; fifo_clr is not stored, it acts only on the write itself.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         tx_en       <= 1'b0;
         rx_en       <= 1'b0;
         irq_txe_en  <= 1'b0;
         irq_rxne_en <= 1'b0;
      end else if (wr_ctrl) begin
         tx_en       <= wb_dat_i[0];
         rx_en       <= wb_dat_i[1];
         irq_txe_en  <= wb_dat_i[2];
         irq_rxne_en <= wb_dat_i[3];
      end
   end

   // Sticky error flags; a new event in the same cycle as a clear wins.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         rx_overrun  <= 1'b0;
         tx_overflow <= 1'b0;
      end else begin
         if (rx_push && rx_full && !rx_pop)     rx_overrun <= 1'b1;
         else if (wr_status && wb_dat_i[4])     rx_overrun <= 1'b0;
         if (tx_push && tx_full && !tx_pop)     tx_overflow <= 1'b1;
         else if (wr_status && wb_dat_i[5])     tx_overflow <= 1'b0;
      end
   end

   // TX FIFO; storage is reset so tx_data_o reads 0 out of reset.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) tx_mem[i] <= '0;
         tx_wptr  <= '0;
         tx_rptr  <= '0;
         tx_count <= '0;
      end else if (fifo_clr) begin
         tx_wptr  <= '0;
         tx_rptr  <= '0;
         tx_count <= '0;
      end else begin
         if (tx_push_ok) begin
            tx_mem[tx_wptr] <= wb_dat_i;
            tx_wptr         <= tx_wptr + 1'b1;
         end
         if (tx_pop) tx_rptr <= tx_rptr + 1'b1;
         case ({tx_push_ok, tx_pop})
            2'b10:   tx_count <= tx_count + 1'b1;
            2'b01:   tx_count <= tx_count - 1'b1;
            default: tx_count <= tx_count;
         endcase
      end
   end

   // RX FIFO; a pop in the same cycle frees room for a push into a full FIFO.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) rx_mem[i] <= '0;
         rx_wptr  <= '0;
         rx_rptr  <= '0;
         rx_count <= '0;
      end else if (fifo_clr) begin
         rx_wptr  <= '0;
         rx_rptr  <= '0;
         rx_count <= '0;
      end else begin
         if (rx_push_ok) begin
            rx_mem[rx_wptr] <= rx_data_i;
            rx_wptr         <= rx_wptr + 1'b1;
         end
         if (rx_pop) rx_rptr <= rx_rptr + 1'b1;
         case ({rx_push_ok, rx_pop})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: rx_count <= rx_count;
         endcase
      end
   end

   assign tx_count5 = 5'(tx_count);
   assign rx_count5 = 5'(rx_count);

   assign status_word = {11'd0, rx_count5, 3'd0, tx_count5, 2'd0,
                         tx_overflow, rx_overrun, rx_empty, rx_full,
                         tx_empty, tx_full};

   // Read data is driven only during an acked read, zero at all other times.
   always_comb begin
      rd_data = '0;
      if (rd) begin
         case (reg_sel)
            REG_CTRL:   rd_data = {28'd0, irq_rxne_en, irq_txe_en, rx_en, tx_en};
            REG_STATUS: rd_data = status_word;
            REG_TXDATA: rd_data = '0;
            REG_RXDATA: rd_data = rx_empty ? 32'd0 : rx_mem[rx_rptr];
            default:    rd_data = '0;
         endcase
      end
   end

   assign wb_dat_o = rd_data;

   // Registered interrupt from the enabled FIFO level conditions.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) irq_o <= 1'b0;
      else           irq_o <= (irq_txe_en & tx_empty) | (irq_rxne_en & ~rx_empty);
   end

endmodule

// File: tb/tb_i2s_wb_slave.sv
// Directed bench for i2s_wb_slave: register map, FIFO behaviour, interrupt
// and reset handling, with hand-computed expected values.
module tb_i2s_wb_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, sel = 1'b0;
   logic [31:0] adr = '0, dat_w = '0;
   logic [2:0]  cti = 3'd0;
   logic [1:0]  bte = 2'd0;
   logic [31:0] dat_r;
   logic        ack;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [31:0] rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        irq;

   int total = 0;
   int bad   = 0;
   logic [31:0] rdata;

   i2s_wb_slave #(.FIFO_DEPTH(4)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst_n),
      .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
      .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_cti_i(cti), .wb_bte_i(bte),
      .wb_dat_o(dat_r), .wb_ack_o(ack),
      .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
      .rx_data_i(rx_data), .rx_valid_i(rx_valid), .irq_o(irq)
   );

   always #5 clk = ~clk;

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic s);
      bit got;
      got = 1'b0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = s;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (ack) begin got = 1'b1; break; end
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL write_ack addr=%h got no ack, required ack", a);
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 1'b0;
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
      bit got;
      got = 1'b0;
      d = '0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (ack) begin got = 1'b1; d = dat_r; break; end
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL read_ack addr=%h got no ack, required ack", a);
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; sel = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({ack, tx_valid, irq} !== 3'b000) begin
         bad++; $display("FAIL reset_outs got %b required 000", {ack, tx_valid, irq});
      end
      total++;
      if (dat_r !== 32'd0 || tx_data !== 32'd0) begin
         bad++; $display("FAIL reset_data got dat=%h tx=%h required 0", dat_r, tx_data);
      end
      @(negedge clk); rst_n = 1'b1;
      wb_read(32'h4, rdata);
      total++;
      if (rdata !== 32'h0000_000A) begin
         bad++; $display("FAIL reset_status got %h required 0000000a", rdata);
      end
      wb_read(32'h0, rdata);
      total++;
      if (rdata !== 32'h0) begin
         bad++; $display("FAIL reset_ctrl got %h required 0", rdata);
      end
   endtask

   task automatic test_tx_overflow();
      logic [31:0] exp;
      wb_write(32'h0, 32'h1, 1'b1);
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) wb_write(32'h8, 32'h11 * (i + 1), 1'b1);
      wb_read(32'h4, rdata);
      total++;
      if (rdata !== 32'h0000_0429) begin
         bad++; $display("FAIL tx_full_status got %h required 00000429", rdata);
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (!tx_valid || tx_data !== 32'h11) begin
         bad++; $display("FAIL tx_hold got v=%b d=%h required v=1 d=00000011", tx_valid, tx_data);
      end
      @(negedge clk); tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp = 32'h11 * (i + 1);
         total++;
         if (!tx_valid || tx_data !== exp) begin
            bad++; $display("FAIL tx_drain[%0d] got v=%b d=%h required v=1 d=%h", i, tx_valid, tx_data, exp);
         end
         @(negedge clk);
      end
      total++;
      if (tx_valid !== 1'b0) begin
         bad++; $display("FAIL tx_drained_valid got %b required 0", tx_valid);
      end
      tx_ready = 1'b0;
      wb_write(32'h4, 32'h20, 1'b1);
      wb_read(32'h4, rdata);
      total++;
      if (rdata !== 32'h0000_000A) begin
         bad++; $display("FAIL tx_ovf_clear got %h required 0000000a", rdata);
      end
   endtask

   task automatic test_rx_overrun();
      logic [31:0] exp;
      wb_write(32'h0, 32'h2, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); rx_valid = 1'b1; rx_data = 32'hA0 + i;
      end
      @(negedge clk); rx_valid = 1'b0; rx_data = '0;
      wb_read(32'h4, rdata);
      total++;
      if (rdata !== 32'h0004_0016) begin
         bad++; $display("FAIL rx_full_status got %h required 00040016", rdata);
      end
      for (int i = 0; i < 4; i++) begin
         exp = 32'hA0 + i;
         wb_read(32'hC, rdata);
         total++;
         if (rdata !== exp) begin
            bad++; $display("FAIL rx_read[%0d] got %h required %h", i, rdata, exp);
         end
      end
      wb_read(32'hC, rdata);
      total++;
      if (rdata !== 32'h0) begin
         bad++; $display("FAIL rx_read_empty got %h required 0", rdata);
      end
      wb_read(32'h4, rdata);
      total++;
      if (rdata !== 32'h0000_001A) begin
         bad++; $display("FAIL rx_empty_status got %h required 0000001a", rdata);
      end
      wb_write(32'h4, 32'h10, 1'b1);
      wb_read(32'h4, rdata);
      total++;
      if (rdata !== 32'h0000_000A) begin
         bad++; $display("FAIL rx_ovr_clear got %h required 0000000a", rdata);
      end
   endtask

   task automatic test_irq();
      wb_write(32'h0, 32'hC, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (irq !== 1'b1) begin
         bad++; $display("FAIL irq_txe got %b required 1", irq);
      end
      wb_write(32'h8, 32'hDEAD_0001, 1'b1);
      total++;
      if (irq !== 1'b1) begin
         bad++; $display("FAIL irq_lag got %b required 1", irq);
      end
      @(posedge clk); #1;
      total++;
      if (irq !== 1'b0) begin
         bad++; $display("FAIL irq_drop got %b required 0", irq);
      end
      wb_read(32'h4, rdata);
      total++;
      if (rdata !== 32'h0000_0108) begin
         bad++; $display("FAIL irq_status got %h required 00000108", rdata);
      end
      wb_write(32'h0, 32'h1C, 1'b1);
      wb_read(32'h0, rdata);
      total++;
      if (rdata !== 32'hC) begin
         bad++; $display("FAIL clr_ctrl got %h required 0000000c", rdata);
      end
      wb_read(32'h4, rdata);
      total++;
      if (rdata !== 32'h0000_000A || irq !== 1'b1) begin
         bad++; $display("FAIL clr_status got %h irq=%b required 0000000a irq=1", rdata, irq);
      end
   endtask

   task automatic test_unmapped();
      wb_write(32'h10, 32'hFFFF_FFFF, 1'b1);
      wb_write(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wb_read(32'h10, rdata);
      total++;
      if (rdata !== 32'h0) begin
         bad++; $display("FAIL unmapped_10 got %h required 0", rdata);
      end
      wb_read(32'h8000_0000, rdata);
      total++;
      if (rdata !== 32'h0) begin
         bad++; $display("FAIL unmapped_hi got %h required 0", rdata);
      end
      wb_read(32'h4, rdata);
      total++;
      if (rdata !== 32'h0000_000A) begin
         bad++; $display("FAIL unmapped_status got %h required 0000000a", rdata);
      end
      wb_write(32'h0, 32'h3, 1'b0);
      wb_read(32'h1, rdata);
      total++;
      if (rdata !== 32'hC) begin
         bad++; $display("FAIL sel0_ctrl got %h required 0000000c", rdata);
      end
      wb_read(32'h8, rdata);
      total++;
      if (rdata !== 32'h0) begin
         bad++; $display("FAIL txdata_read got %h required 0", rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic exp_ack;
      logic [31:0] exp_dat;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         exp_ack = (i % 2 == 0);
         exp_dat = exp_ack ? 32'hC : 32'h0;
         total++;
         if (ack !== exp_ack || dat_r !== exp_dat) begin
            bad++; $display("FAIL held_strobe[%0d] got ack=%b dat=%h required ack=%b dat=%h",
                            i, ack, dat_r, exp_ack, exp_dat);
         end
      end
      cyc = 1'b0; stb = 1'b0; sel = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit seen;
      wb_write(32'h0, 32'h0, 1'b1);
      wb_write(32'h8, 32'h1, 1'b1);
      wb_write(32'h8, 32'h2, 1'b1);
      wb_read(32'h4, rdata);
      total++;
      if (rdata !== 32'h0000_0208) begin
         bad++; $display("FAIL pre_reset_status got %h required 00000208", rdata);
      end
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4; sel = 1'b1;
      @(posedge clk); #1;
      total++;
      if (ack !== 1'b1) begin
         bad++; $display("FAIL mid_ack got %b required 1", ack);
      end
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      total++;
      if (ack !== 1'b0 || dat_r !== 32'h0 || tx_data !== 32'h0) begin
         bad++; $display("FAIL async_reset got ack=%b dat=%h tx=%h required 0", ack, dat_r, tx_data);
      end
      @(negedge clk); cyc = 1'b0; stb = 1'b0; sel = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (ack) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++; $display("FAIL stale_ack got ack after reset required none");
      end
      wb_read(32'h4, rdata);
      total++;
      if (rdata !== 32'h0000_000A) begin
         bad++; $display("FAIL post_reset_status got %h required 0000000a", rdata);
      end
   endtask

   initial begin
      test_reset();
      test_tx_overflow();
      test_rx_overrun();
      test_irq();
      test_unmapped();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1);
   end

endmodule
